mult_product_assembler: RTL and testbench
=========================================

# mult_product_assembler

Back end of the 8-bit-sliced vector multiplier. Takes the eight unsigned 8x8 magnitude products from the multiplier array, with the per-lane sign bits issued by the operand splitter. Shifts and sums them into 8-, 16- or 32-bit element products and applies two's-complement sign correction. Emits one registered 64-bit result per element group. For SEW=32 it accumulates two passes, selected by `count_0`.

## Interface
- Parameters: none; widths are fixed at 8-bit slices, 32-bit operands and a 64-bit result.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `valid_in` in 1: product/sign bundle valid this cycle.
- `sew` in 2: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit; 11 is reserved.
- `count_0` in 1: SEW=32 pass select; 0 = low pass (B bytes 0,1), 1 = high pass (B bytes 2,3).
- `prod1`..`prod8` in 16 each: unsigned magnitude products.
- `sign_A0`..`sign_A3`, `sign_B0`..`sign_B3` in 1 each: lane operand signs; 1 = negative.
- `result` out 64: assembled products.
- `out_valid` out 1: one-cycle pulse when `result` is updated.
- `seq_err` out 1: one-cycle pulse on a pass-sequencing violation.

## Operation

Lane mapping; `ai` and `bi` are magnitude bytes.

**sew=00**
- Lane k (k=0..3) = `prod(k+1)`; `prod5`..`prod8` are ignored.
- Lane k is negated in 16 bits if `sign_Ak ^ sign_Bk`.
- `result[16k+15:16k]` = lane k.

**sew=01**
- Lane 0 = `prod1 + (prod2<<8) + (prod3<<8) + (prod4<<16)`, where `prod1..4` = a0b0, a0b1, a1b0, a1b1.
- Lane 1 is the same sum over `prod5..8` = a2b2, a2b3, a3b2, a3b3.
- Lane L is negated in 32 bits if `sign_AL ^ sign_BL`.
- `result[32L+31:32L]` = lane L.

**sew=10**
- Each pass supplies `prod1..4` = a0..a3 × b_lo and `prod5..8` = a0..a3 × b_hi.
- Pass sum P = Σ `prod(i+1)<<8i` + Σ `prod(i+5)<<(8i+8)`, i = 0..3, in 64-bit arithmetic.
- Pass 0 (`count_0=0`) stores P in a 64-bit accumulator.
- Pass 1 (`count_0=1`) computes acc + (P<<16).
- The final sum is negated in 64 bits if `sign_A0 ^ sign_B0`; the signs are sampled on pass 1.

All sums are computed unsigned, with no truncation before the final lane width.

**FSM states and transitions**
- `IDLE` → `WAIT_HI` on `valid_in & sew==10 & !count_0`.
- `WAIT_HI` → `IDLE` on `valid_in & sew==10 & count_0`: result is produced.
- `IDLE` with `valid_in` and sew 00/01: single-pass result is produced; stays in `IDLE`.
- `IDLE` with `valid_in & sew==10 & count_0`: `seq_err` pulses, no result, stays in `IDLE`.
- `WAIT_HI` with `valid_in & sew==10 & !count_0`:
  - the accumulator is overwritten and `seq_err` pulses;
  - state stays `WAIT_HI`.
- `WAIT_HI` with `valid_in` and sew 00/01:
  - the accumulator is discarded and `seq_err` pulses;
  - the single-pass result is produced;
  - state goes to `IDLE`.
- `sew=11` with `valid_in`: `seq_err` pulses, state goes to `IDLE`, no result.
- `valid_in=0`: no state change.

## Timing
- Reset values: `result`=0, `out_valid`=0, `seq_err`=0, accumulator=0, state=`IDLE`.
- Reset asserted between passes discards the partial result. A later pass 1 is treated as the `IDLE` error case.
- Latency for sew 00/01: `out_valid` and `result` appear the cycle after `valid_in`.
- Latency for sew 10: `out_valid` appears the cycle after the pass-1 `valid_in`. Passes need not be consecutive.
- Throughput: accepts `valid_in` every cycle; there is no backpressure.
- `result` holds its value until the next `out_valid`.
- `seq_err` is registered and asserts in the same cycle slot as `out_valid` would.

## Structure
- Shared package `mult_pkg` holds:
  - `sew_e` enum (`SEW8`=00, `SEW16`=01, `SEW32`=10);
  - `asm_state_e` (`IDLE`, `WAIT_HI`);
  - constants `SLICE_W`=8 and `RES_W`=64.
- One sub-module, `mult_sign_fix`: a combinational conditional two's-complement negate over a 64-bit value, with lane partitioning driven by `sew`.

## Test plan
1. sew=00, `prod1`=0x0006, `sign_A0`=1, `sign_B0`=0, `prod2`=0x0009 with both signs 0 → next cycle `out_valid`=1, `result[15:0]`=0xFFFA, `result[31:16]`=0x0009.
2. sew=01, `prod1`=0x0001, `prod2..4`=0, `sign_A0`=`sign_B0`=1 → `result[31:0]`=0x00000001, with no negation.
3. sew=10 unsigned 0xFFFFFFFF × 0xFFFFFFFF: all `prod`=0xFE01 on both passes, all signs 0.
   - `out_valid` is low after pass 0.
   - One cycle after pass 1, `result`=0xFFFFFFFE00000001.
4. Pass 1 (sew=10, `count_0`=1) while in `IDLE` → `seq_err` pulses one cycle; `out_valid` stays 0; `result` is unchanged.
5. Pass 0, then `reset` for one cycle, then pass 1 → `result`=0 after reset; pass 1 raises `seq_err` and no `out_valid`.
6. Back-to-back sew=00 `valid_in` on 4 consecutive cycles with distinct products → 4 consecutive `out_valid` pulses, each `result` matching its input one cycle later.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the sliced vector multiplier back end.
package mult_pkg;

    localparam int SLICE_W = 8;
    localparam int RES_W   = 64;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    typedef enum logic {
        IDLE,
        WAIT_HI
    } asm_state_e;

    // Zero-extend a 16-bit slice product to result width and move it into place.
    function automatic logic [RES_W-1:0] place(input logic [15:0] p, input int unsigned sh);
        return {{(RES_W-16){1'b0}}, p} << sh;
    endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// Conditional two's-complement negate of a 64-bit value, partitioned into
// 16-, 32- or 64-bit lanes according to the element width.
module mult_sign_fix
    import mult_pkg::*;
(
    input  logic [1:0]       sew_i,
    input  logic [3:0]       neg_i,
    input  logic [RES_W-1:0] val_i,
    output logic [RES_W-1:0] res_o
);

    always_comb begin
        res_o = val_i;
        case (sew_e'(sew_i))
            SEW8: begin
                for (int k = 0; k < 4; k++) begin
                    if (neg_i[k]) res_o[16*k +: 16] = -val_i[16*k +: 16];
                end
            end
            SEW16: begin
                for (int l = 0; l < 2; l++) begin
                    if (neg_i[l]) res_o[32*l +: 32] = -val_i[32*l +: 32];
                end
            end
            SEW32: begin
                if (neg_i[0]) res_o = -val_i;
            end
            default: res_o = val_i;
        endcase
    end

endmodule

// File: rtl/mult_product_assembler.sv
// Shifts and sums the eight slice products into 8/16/32-bit element products,
// sign-corrects them and sequences the two-pass SEW=32 accumulation.
module mult_product_assembler
    import mult_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [1:0]  sew,
    input  logic        count_0,
    input  logic [15:0] prod1,
    input  logic [15:0] prod2,
    input  logic [15:0] prod3,
    input  logic [15:0] prod4,
    input  logic [15:0] prod5,
    input  logic [15:0] prod6,
    input  logic [15:0] prod7,
    input  logic [15:0] prod8,
    input  logic        sign_A0,
    input  logic        sign_A1,
    input  logic        sign_A2,
    input  logic        sign_A3,
    input  logic        sign_B0,
    input  logic        sign_B1,
    input  logic        sign_B2,
    input  logic        sign_B3,
    output logic [63:0] result,
    output logic        out_valid,
    output logic        seq_err
);

    asm_state_e       state_q;
    logic [RES_W-1:0] acc_q;

    logic [3:0]       lane_neg;
    logic [31:0]      lane16_lo;
    logic [31:0]      lane16_hi;
    logic [RES_W-1:0] pass_sum;
    logic [RES_W-1:0] asm_val;
    logic [RES_W-1:0] result_d;

    assign lane_neg = {sign_A3 ^ sign_B3, sign_A2 ^ sign_B2,
                       sign_A1 ^ sign_B1, sign_A0 ^ sign_B0};

    always_comb begin
        lane16_lo = {16'b0, prod1} + {8'b0, prod2, 8'b0} + {8'b0, prod3, 8'b0} + {prod4, 16'b0};
        lane16_hi = {16'b0, prod5} + {8'b0, prod6, 8'b0} + {8'b0, prod7, 8'b0} + {prod8, 16'b0};

        // prod1..4 weight the low B byte, prod5..8 the next byte up.
        pass_sum = place(prod1, 0)           + place(prod2, SLICE_W)
                 + place(prod3, 2*SLICE_W)   + place(prod4, 3*SLICE_W)
                 + place(prod5, SLICE_W)     + place(prod6, 2*SLICE_W)
                 + place(prod7, 3*SLICE_W)   + place(prod8, 4*SLICE_W);

        case (sew_e'(sew))
            SEW8:    asm_val = {prod4, prod3, prod2, prod1};
            SEW16:   asm_val = {lane16_hi, lane16_lo};
            SEW32:   asm_val = acc_q + (pass_sum << (2*SLICE_W));
            default: asm_val = '0;
        endcase
    end

    mult_sign_fix u_sign_fix (
        .sew_i (sew),
        .neg_i (lane_neg),
        .val_i (asm_val),
        .res_o (result_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            seq_err   <= 1'b0;
            if (valid_in) begin
                case (sew_e'(sew))
                    SEW8, SEW16: begin
                        result    <= result_d;
                        out_valid <= 1'b1;
                        seq_err   <= (state_q == WAIT_HI);
                        acc_q     <= '0;
                        state_q   <= IDLE;
                    end
                    SEW32: begin
                        if (!count_0) begin
                            // A repeated low pass replaces, never adds to, the partial sum.
                            acc_q   <= pass_sum;
                            seq_err <= (state_q == WAIT_HI);
                            state_q <= WAIT_HI;
                        end else if (state_q == WAIT_HI) begin
                            result    <= result_d;
                            out_valid <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            seq_err <= 1'b1;
                        end
                    end
                    default: begin
                        seq_err <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_product_assembler.sv
// Scoreboard bench for mult_product_assembler with directed vectors.
module tb_mult_product_assembler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [1:0]  sew = 2'b00;
    logic        count_0 = 1'b0;
    logic [15:0] p [8];
    logic [3:0]  sa = 4'b0;
    logic [3:0]  sb = 4'b0;
    logic [63:0] result;
    logic        out_valid;
    logic        seq_err;

    typedef struct {
        logic        ov;
        logic        err;
        logic [63:0] res;
    } exp_t;

    exp_t        sb_q [$];
    logic [63:0] last_res = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mult_product_assembler dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .sew       (sew),
        .count_0   (count_0),
        .prod1     (p[0]),
        .prod2     (p[1]),
        .prod3     (p[2]),
        .prod4     (p[3]),
        .prod5     (p[4]),
        .prod6     (p[5]),
        .prod7     (p[6]),
        .prod8     (p[7]),
        .sign_A0   (sa[0]),
        .sign_A1   (sa[1]),
        .sign_A2   (sa[2]),
        .sign_A3   (sa[3]),
        .sign_B0   (sb[0]),
        .sign_B1   (sb[1]),
        .sign_B2   (sb[2]),
        .sign_B3   (sb[3]),
        .result    (result),
        .out_valid (out_valid),
        .seq_err   (seq_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic ov, input logic err, input logic [63:0] r);
        exp_t e;
        if (ov) last_res = r;
        e.ov  = ov;
        e.err = err;
        e.res = ov ? r : last_res;
        sb_q.push_back(e);
    endtask

    // pv packs {prod8, ..., prod1}.
    task automatic send(input logic [1:0] s, input logic c0, input logic [127:0] pv,
                        input logic [3:0] a, input logic [3:0] b);
        @(posedge clk);
        #1;
        sew      = s;
        count_0  = c0;
        sa       = a;
        sb       = b;
        valid_in = 1'b1;
        for (int i = 0; i < 8; i++) p[i] = pv[16*i +: 16];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (out_valid || seq_err)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: out_valid=%0b seq_err=%0b result=0x%016h with nothing expected",
                         out_valid, seq_err, result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_valid", {63'b0, out_valid}, {63'b0, e.ov});
                check("seq_err", {63'b0, seq_err}, {63'b0, e.err});
                check("result", result, e.res);
            end
        end
    end

    localparam logic [127:0] ALL_FE01 = {8{16'hFE01}};

    initial begin
        for (int i = 0; i < 8; i++) p[i] = '0;
        idle(2);
        reset = 1'b0;
        #1;
        check("reset_result", result, 64'h0);
        check("reset_out_valid", {63'b0, out_valid}, 64'h0);
        check("reset_seq_err", {63'b0, seq_err}, 64'h0);

        // sew=8 with lane 0 negated
        send(2'b00, 1'b0, {96'h0, 16'h0009, 16'h0006}, 4'b0001, 4'b0000);
        expect_ev(1'b1, 1'b0, 64'h0000_0000_0009_FFFA);

        // sew=16, equal signs leave the product positive
        send(2'b01, 1'b0, {112'h0, 16'h0001}, 4'b0001, 4'b0001);
        expect_ev(1'b1, 1'b0, 64'h0000_0000_0000_0001);

        // sew=16 both lanes, lane 1 negative
        send(2'b01, 1'b0, {16'h4, 16'h3, 16'h2, 16'h1, 16'h4, 16'h3, 16'h2, 16'h1},
             4'b0010, 4'b0000);
        expect_ev(1'b1, 1'b0, 64'hFFFB_FAFF_0004_0501);
        idle(1);

        // sew=32 full-scale unsigned, passes separated by idle cycles
        send(2'b10, 1'b0, ALL_FE01, 4'b0, 4'b0);
        idle(1);
        check("pass0_no_out_valid", {63'b0, out_valid}, 64'h0);
        check("pass0_no_seq_err", {63'b0, seq_err}, 64'h0);
        idle(2);
        send(2'b10, 1'b1, ALL_FE01, 4'b0, 4'b0);
        expect_ev(1'b1, 1'b0, 64'hFFFF_FFFE_0000_0001);
        idle(1);

        // pass 1 with no pending pass 0
        send(2'b10, 1'b1, ALL_FE01, 4'b0, 4'b0);
        expect_ev(1'b0, 1'b1, 64'h0);
        idle(1);

        // sew=32 signed: -1 * 1, signs taken from pass 1 only
        send(2'b10, 1'b0, {112'h0, 16'h0001}, 4'b0000, 4'b0000);
        send(2'b10, 1'b1, 128'h0, 4'b0001, 4'b0000);
        expect_ev(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

        // repeated pass 0 overwrites the accumulator
        send(2'b10, 1'b0, {112'h0, 16'h0005}, 4'b0, 4'b0);
        send(2'b10, 1'b0, {112'h0, 16'h0007}, 4'b0, 4'b0);
        expect_ev(1'b0, 1'b1, 64'h0);
        send(2'b10, 1'b1, 128'h0, 4'b0, 4'b0);
        expect_ev(1'b1, 1'b0, 64'h0000_0000_0000_0007);

        // single-pass op while waiting for pass 1, then orphan pass 1
        send(2'b10, 1'b0, {112'h0, 16'h0009}, 4'b0, 4'b0);
        send(2'b00, 1'b0, {112'h0, 16'h0003}, 4'b0, 4'b0);
        expect_ev(1'b1, 1'b1, 64'h0000_0000_0000_0003);
        send(2'b10, 1'b1, 128'h0, 4'b0, 4'b0);
        expect_ev(1'b0, 1'b1, 64'h0);

        // reserved sew
        send(2'b11, 1'b0, {112'h0, 16'h0055}, 4'b0, 4'b0);
        expect_ev(1'b0, 1'b1, 64'h0);
        idle(1);

        // reset between passes discards the partial sum
        send(2'b10, 1'b0, ALL_FE01, 4'b0, 4'b0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        last_res = '0;
        check("midreset_result", result, 64'h0);
        check("midreset_out_valid", {63'b0, out_valid}, 64'h0);
        send(2'b10, 1'b1, ALL_FE01, 4'b0, 4'b0);
        expect_ev(1'b0, 1'b1, 64'h0);
        idle(1);

        // back-to-back sew=8 stream
        send(2'b00, 1'b0, {64'h0, 16'h4, 16'h3, 16'h2, 16'h1}, 4'b0000, 4'b0000);
        expect_ev(1'b1, 1'b0, 64'h0004_0003_0002_0001);
        send(2'b00, 1'b0, {64'h0, 16'h40, 16'h30, 16'h20, 16'h10}, 4'b1010, 4'b0000);
        expect_ev(1'b1, 1'b0, 64'hFFC0_0030_FFE0_0010);
        send(2'b00, 1'b0, {64'h0, 16'h0, 16'h0, 16'h5, 16'h0}, 4'b1111, 4'b0000);
        expect_ev(1'b1, 1'b0, 64'h0000_0000_FFFB_0000);
        send(2'b00, 1'b0, {{4{16'hEEEE}}, 16'h0100, 16'hFE01, 16'hABCD, 16'h1234},
             4'b0011, 4'b0001);
        expect_ev(1'b1, 1'b0, 64'h0100_FE01_5433_1234);
        idle(4);

        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
